alu_reservation_station: RTL and testbench
==========================================

# alu_reservation_station

Reservation station that sits directly upstream of the functional-unit block and feeds its ALU port. It holds up to `RS_SIZE` dispatched ALU micro-ops, wakes them up from the single FU→ROB result broadcast, and issues the oldest ready entry as a one-cycle start pulse with both operand values resolved. Ordering is kept by a collapsing queue, so slot 0 is always the oldest entry.

## Interface
Parameters:
- `RS_SIZE`, 4: number of entries (≥2).
- `GPR_SIZE`, 64: operand width (codebase macro value).
- `ROB_IDX_SIZE`, 4: ROB tag width (codebase macro value).

Ports:
- `in_clk`  in  1  clock. One clock; all state is updated on its rising edge.
- `in_rst`  in  1  reset. Asynchronous, active-high.
- `in_flush`  in  1  mispredict flush; empties the station.
- `in_dispatch_valid`  in  1  new micro-op present this cycle.
- `in_dispatch_fu_op`  in  fu_op_t  operation.
- `in_dispatch_val_a` / `in_dispatch_val_b`  in  GPR_SIZE  operand value, meaningful when the matching ready bit is 1.
- `in_dispatch_a_ready` / `in_dispatch_b_ready`  in  1  operand already available.
- `in_dispatch_a_tag` / `in_dispatch_b_tag`  in  ROB_IDX_SIZE  producer ROB index, used when the matching ready bit is 0.
- `in_dispatch_dst_rob_index`  in  ROB_IDX_SIZE  destination tag.
- `in_dispatch_set_nzcv`  in  1  passed through to the FU.
- `in_dispatch_nzcv`  in  nzcv_t  passed through to the FU.
- `in_dispatch_cond`  in  cond_t  passed through to the FU.
- `in_fu_done`  in  1  result broadcast valid.
- `in_fu_dst_rob_index`  in  ROB_IDX_SIZE  broadcast tag.
- `in_fu_value`  in  GPR_SIZE  broadcast value.
- `in_fu_alu_ready`  in  1  the ALU accepts a start this cycle.
- `out_dispatch_full`  out  1  all entries valid; dispatch is refused.
- `out_fu_alu_start`  out  1  one-cycle issue pulse.
- `out_fu_alu_fu_op`, `out_fu_alu_val_a`, `out_fu_alu_val_b`, `out_fu_alu_dst_rob_index`, `out_fu_alu_set_nzcv`, `out_fu_alu_nzcv`, `out_fu_alu_cond`  out  (matching widths)  issued payload. Registered, held until the next issue.

## Operation
- Each entry holds: valid, op, val_a/val_b, a_rdy/b_rdy, a_tag/b_tag, dst, set_nzcv, nzcv, cond.
- Valid entries occupy slots 0..count-1 contiguously; slot 0 is the oldest.
- **Wakeup.** On each edge with `in_fu_done`:
  - Every valid entry whose operand is not ready and whose tag equals `in_fu_dst_rob_index` captures `in_fu_value` and sets that operand ready.
  - A and B wake independently; both may match the same broadcast.
- **Dispatch bypass.** A dispatched operand with ready=0 whose tag matches a same-cycle broadcast is written already ready, holding the broadcast value.
- **Select.** Combinational: the lowest-index valid entry with both operands ready, evaluated on registered state only. An entry woken at edge t is selectable in the cycle after edge t.
- **Issue.** Occurs when a ready entry exists, `in_fu_alu_ready`=1 and `in_flush`=0. At the next edge:
  - `out_fu_alu_start`<=1 and the payload registers are loaded from the selected entry.
  - Entries above the selected slot shift down one slot, with their wakeup applied in the same edge.
- **Dispatch.** Accepted when `in_dispatch_valid` && !`out_dispatch_full` && !`in_flush`. It is written to slot count, or to slot count-1 when an issue happens in the same edge.
- **Full.** `out_dispatch_full` = (count == RS_SIZE), taken from registered count.
  - A dispatch while full is dropped, even if an issue frees a slot that same cycle.
- **Flush.** Takes priority over everything. All valid bits clear at the next edge, and `out_fu_alu_start` is 0 at that edge. Payload registers keep their values.
- **Reset.** All valid bits 0, count 0, and every output 0, including the payload registers.
  - Reset mid-operation discards in-flight entries immediately, without waiting for the clock.

## Timing
- Dispatch with both operands ready at edge t: entry becomes valid at t. Earliest `out_fu_alu_start`=1 is after edge t+1 (one-cycle minimum residency).
- Broadcast at edge t waking the last missing operand: issue after edge t+1 at the earliest.
- `out_fu_alu_start` is high for exactly one cycle per issued entry. Back-to-back issues on consecutive cycles are allowed.
- `in_fu_alu_ready`=0 stalls issue. Entries keep waking up while stalled.
- Throughput: one dispatch and one issue per cycle.

## Test plan
- Reset, then dispatch PLUS with a=5 and b=7 both ready, dst=3, with `in_fu_alu_ready`=1 -> start pulse one cycle after the dispatch edge with val_a=5, val_b=7, dst=3. `out_dispatch_full` stays 0.
- Dispatch an entry with a_tag=2 not ready, then broadcast tag 2 value 0x10 two cycles later -> issue the cycle after the broadcast edge with val_a=0x10. Also broadcast tag 2 in the same cycle as a dispatch with a_tag=2 -> captured; issue after one cycle.
- Fill 4 entries where only slots 1 and 3 are ready -> slot 1 issues first, then slot 3. The remaining entries compact to slots 0–1. `out_dispatch_full` goes 1 -> 0 after the first issue.
- While full, assert dispatch together with an issue -> the dispatch is dropped and count becomes 3. Dispatch on the next cycle -> accepted into slot 3.
- Hold `in_fu_alu_ready`=0 for 3 cycles with 2 ready entries -> no start pulses. Release -> two consecutive single-cycle pulses, oldest first.
- With 3 valid entries, assert `in_flush` together with a dispatch -> no start pulse and count=0. Also assert `in_rst` asynchronously mid-cycle -> outputs 0 immediately.

Source files
------------

// File: rtl/alu_rs_pkg.sv
// Shared ALU micro-op field types used by the reservation station and its neighbours.
package alu_rs_pkg;

  typedef enum logic [2:0] {
    FU_PLUS,
    FU_MINUS,
    FU_AND,
    FU_ORR,
    FU_EOR,
    FU_LSL,
    FU_LSR,
    FU_MOV
  } fu_op_t;

  typedef logic [3:0] nzcv_t;
  typedef logic [3:0] cond_t;

endpackage

// File: rtl/alu_reservation_station.sv
// ALU reservation station: a collapsing queue of dispatched micro-ops (slot 0 is
// always the oldest) that wakes operands from the result broadcast and issues the
// oldest fully-ready entry to the ALU as a registered one-cycle start pulse.
module alu_reservation_station
  import alu_rs_pkg::*;
#(
  parameter int RS_SIZE      = 4,
  parameter int GPR_SIZE     = 64,
  parameter int ROB_IDX_SIZE = 4
) (
  input  logic                    in_clk,
  input  logic                    in_rst,
  input  logic                    in_flush,
  input  logic                    in_dispatch_valid,
  input  fu_op_t                  in_dispatch_fu_op,
  input  logic [GPR_SIZE-1:0]     in_dispatch_val_a,
  input  logic [GPR_SIZE-1:0]     in_dispatch_val_b,
  input  logic                    in_dispatch_a_ready,
  input  logic                    in_dispatch_b_ready,
  input  logic [ROB_IDX_SIZE-1:0] in_dispatch_a_tag,
  input  logic [ROB_IDX_SIZE-1:0] in_dispatch_b_tag,
  input  logic [ROB_IDX_SIZE-1:0] in_dispatch_dst_rob_index,
  input  logic                    in_dispatch_set_nzcv,
  input  nzcv_t                   in_dispatch_nzcv,
  input  cond_t                   in_dispatch_cond,
  input  logic                    in_fu_done,
  input  logic [ROB_IDX_SIZE-1:0] in_fu_dst_rob_index,
  input  logic [GPR_SIZE-1:0]     in_fu_value,
  input  logic                    in_fu_alu_ready,
  output logic                    out_dispatch_full,
  output logic                    out_fu_alu_start,
  output fu_op_t                  out_fu_alu_fu_op,
  output logic [GPR_SIZE-1:0]     out_fu_alu_val_a,
  output logic [GPR_SIZE-1:0]     out_fu_alu_val_b,
  output logic [ROB_IDX_SIZE-1:0] out_fu_alu_dst_rob_index,
  output logic                    out_fu_alu_set_nzcv,
  output nzcv_t                   out_fu_alu_nzcv,
  output cond_t                   out_fu_alu_cond
);

  localparam int CNT_W = $clog2(RS_SIZE + 1);

  typedef struct packed {
    logic                    valid;
    fu_op_t                  op;
    logic [GPR_SIZE-1:0]     val_a;
    logic [GPR_SIZE-1:0]     val_b;
    logic                    a_rdy;
    logic                    b_rdy;
    logic [ROB_IDX_SIZE-1:0] a_tag;
    logic [ROB_IDX_SIZE-1:0] b_tag;
    logic [ROB_IDX_SIZE-1:0] dst;
    logic                    set_nzcv;
    nzcv_t                   nzcv;
    cond_t                   cond;
  } entry_t;

  entry_t           rs_q  [RS_SIZE];
  entry_t           rs_w  [RS_SIZE];
  entry_t           rs_up [RS_SIZE];
  entry_t           rs_d  [RS_SIZE];
  entry_t           dis_e;
  entry_t           sel_e;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             has_sel;
  int               sel_idx;
  int               wr_idx;
  logic             issue;
  logic             accept;

  assign out_dispatch_full = (count_q == CNT_W'(RS_SIZE));
  assign issue             = has_sel && in_fu_alu_ready && !in_flush;
  assign accept            = in_dispatch_valid && !out_dispatch_full && !in_flush;

  // Wakeup: stored entries capture a matching broadcast, A and B independently.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      rs_w[i] = rs_q[i];
      if (in_fu_done && rs_q[i].valid) begin
        if (!rs_q[i].a_rdy && (rs_q[i].a_tag == in_fu_dst_rob_index)) begin
          rs_w[i].a_rdy = 1'b1;
          rs_w[i].val_a = in_fu_value;
        end
        if (!rs_q[i].b_rdy && (rs_q[i].b_tag == in_fu_dst_rob_index)) begin
          rs_w[i].b_rdy = 1'b1;
          rs_w[i].val_b = in_fu_value;
        end
      end
    end
  end

  // Select the oldest entry whose operands were both ready before this edge.
  always_comb begin
    has_sel = 1'b0;
    sel_idx = 0;
    sel_e   = rs_q[0];
    for (int i = 0; i < RS_SIZE; i++) begin
      if (!has_sel && rs_q[i].valid && rs_q[i].a_rdy && rs_q[i].b_rdy) begin
        has_sel = 1'b1;
        sel_idx = i;
        sel_e   = rs_q[i];
      end
    end
  end

  // Incoming micro-op, with a same-cycle broadcast folded in so it is not missed.
  always_comb begin
    dis_e          = '0;
    dis_e.valid    = 1'b1;
    dis_e.op       = in_dispatch_fu_op;
    dis_e.val_a    = in_dispatch_val_a;
    dis_e.val_b    = in_dispatch_val_b;
    dis_e.a_rdy    = in_dispatch_a_ready;
    dis_e.b_rdy    = in_dispatch_b_ready;
    dis_e.a_tag    = in_dispatch_a_tag;
    dis_e.b_tag    = in_dispatch_b_tag;
    dis_e.dst      = in_dispatch_dst_rob_index;
    dis_e.set_nzcv = in_dispatch_set_nzcv;
    dis_e.nzcv     = in_dispatch_nzcv;
    dis_e.cond     = in_dispatch_cond;
    if (!in_dispatch_a_ready && in_fu_done && (in_dispatch_a_tag == in_fu_dst_rob_index)) begin
      dis_e.a_rdy = 1'b1;
      dis_e.val_a = in_fu_value;
    end
    if (!in_dispatch_b_ready && in_fu_done && (in_dispatch_b_tag == in_fu_dst_rob_index)) begin
      dis_e.b_rdy = 1'b1;
      dis_e.val_b = in_fu_value;
    end
  end

  // Next queue contents: collapse over the issued slot, then append the dispatch at the new tail.
  always_comb begin
    for (int i = 0; i < RS_SIZE - 1; i++) begin
      rs_up[i] = rs_w[i+1];
    end
    rs_up[RS_SIZE-1] = '0;
    wr_idx = int'(count_q) - (issue ? 1 : 0);
    for (int i = 0; i < RS_SIZE; i++) begin
      rs_d[i] = (issue && (i >= sel_idx)) ? rs_up[i] : rs_w[i];
      if (accept && (i == wr_idx)) begin
        rs_d[i] = dis_e;
      end
    end
    count_d = count_q;
    if (issue && !accept) begin
      count_d = count_q - 1'b1;
    end else if (accept && !issue) begin
      count_d = count_q + 1'b1;
    end
  end

  // Queue, occupancy and issue payload registers; flush empties the queue but keeps the payload.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        rs_q[i] <= '0;
      end
      count_q                  <= '0;
      out_fu_alu_start         <= 1'b0;
      out_fu_alu_fu_op         <= FU_PLUS;
      out_fu_alu_val_a         <= '0;
      out_fu_alu_val_b         <= '0;
      out_fu_alu_dst_rob_index <= '0;
      out_fu_alu_set_nzcv      <= 1'b0;
      out_fu_alu_nzcv          <= '0;
      out_fu_alu_cond          <= '0;
    end else if (in_flush) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        rs_q[i].valid <= 1'b0;
      end
      count_q          <= '0;
      out_fu_alu_start <= 1'b0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        rs_q[i] <= rs_d[i];
      end
      count_q          <= count_d;
      out_fu_alu_start <= issue;
      if (issue) begin
        out_fu_alu_fu_op         <= sel_e.op;
        out_fu_alu_val_a         <= sel_e.val_a;
        out_fu_alu_val_b         <= sel_e.val_b;
        out_fu_alu_dst_rob_index <= sel_e.dst;
        out_fu_alu_set_nzcv      <= sel_e.set_nzcv;
        out_fu_alu_nzcv          <= sel_e.nzcv;
        out_fu_alu_cond          <= sel_e.cond;
      end
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Bench for alu_reservation_station: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference model.
module tb_alu_reservation_station;
  import alu_rs_pkg::*;

  localparam int RS = 4;

  logic        in_clk;
  logic        in_rst;
  logic        in_flush;
  logic        in_dispatch_valid;
  fu_op_t      in_dispatch_fu_op;
  logic [63:0] in_dispatch_val_a;
  logic [63:0] in_dispatch_val_b;
  logic        in_dispatch_a_ready;
  logic        in_dispatch_b_ready;
  logic [3:0]  in_dispatch_a_tag;
  logic [3:0]  in_dispatch_b_tag;
  logic [3:0]  in_dispatch_dst_rob_index;
  logic        in_dispatch_set_nzcv;
  nzcv_t       in_dispatch_nzcv;
  cond_t       in_dispatch_cond;
  logic        in_fu_done;
  logic [3:0]  in_fu_dst_rob_index;
  logic [63:0] in_fu_value;
  logic        in_fu_alu_ready;
  logic        out_dispatch_full;
  logic        out_fu_alu_start;
  fu_op_t      out_fu_alu_fu_op;
  logic [63:0] out_fu_alu_val_a;
  logic [63:0] out_fu_alu_val_b;
  logic [3:0]  out_fu_alu_dst_rob_index;
  logic        out_fu_alu_set_nzcv;
  nzcv_t       out_fu_alu_nzcv;
  cond_t       out_fu_alu_cond;

  alu_reservation_station #(.RS_SIZE(RS), .GPR_SIZE(64), .ROB_IDX_SIZE(4)) dut (
    .in_clk                   (in_clk),
    .in_rst                   (in_rst),
    .in_flush                 (in_flush),
    .in_dispatch_valid        (in_dispatch_valid),
    .in_dispatch_fu_op        (in_dispatch_fu_op),
    .in_dispatch_val_a        (in_dispatch_val_a),
    .in_dispatch_val_b        (in_dispatch_val_b),
    .in_dispatch_a_ready      (in_dispatch_a_ready),
    .in_dispatch_b_ready      (in_dispatch_b_ready),
    .in_dispatch_a_tag        (in_dispatch_a_tag),
    .in_dispatch_b_tag        (in_dispatch_b_tag),
    .in_dispatch_dst_rob_index(in_dispatch_dst_rob_index),
    .in_dispatch_set_nzcv     (in_dispatch_set_nzcv),
    .in_dispatch_nzcv         (in_dispatch_nzcv),
    .in_dispatch_cond         (in_dispatch_cond),
    .in_fu_done               (in_fu_done),
    .in_fu_dst_rob_index      (in_fu_dst_rob_index),
    .in_fu_value              (in_fu_value),
    .in_fu_alu_ready          (in_fu_alu_ready),
    .out_dispatch_full        (out_dispatch_full),
    .out_fu_alu_start         (out_fu_alu_start),
    .out_fu_alu_fu_op         (out_fu_alu_fu_op),
    .out_fu_alu_val_a         (out_fu_alu_val_a),
    .out_fu_alu_val_b         (out_fu_alu_val_b),
    .out_fu_alu_dst_rob_index (out_fu_alu_dst_rob_index),
    .out_fu_alu_set_nzcv      (out_fu_alu_set_nzcv),
    .out_fu_alu_nzcv          (out_fu_alu_nzcv),
    .out_fu_alu_cond          (out_fu_alu_cond)
  );

  always #5 in_clk = ~in_clk;

  // Reference model: an ordered list of waiting micro-ops plus the expected issue registers.
  typedef struct {
    fu_op_t      op;
    logic [63:0] va;
    logic [63:0] vb;
    logic        ar;
    logic        br;
    logic [3:0]  at;
    logic [3:0]  bt;
    logic [3:0]  dst;
    logic        sn;
    nzcv_t       nz;
    cond_t       cd;
  } ment_t;

  ment_t       q[$];
  logic        e_start;
  fu_op_t      e_op;
  logic [63:0] e_va;
  logic [63:0] e_vb;
  logic [3:0]  e_dst;
  logic        e_sn;
  nzcv_t       e_nz;
  cond_t       e_cd;

  int vectors = 0;
  int errs    = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    e_start = 1'b0;
    e_op    = FU_PLUS;
    e_va    = '0;
    e_vb    = '0;
    e_dst   = '0;
    e_sn    = 1'b0;
    e_nz    = '0;
    e_cd    = '0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    int    sel;
    bit    iss;
    bit    acc;
    ment_t e;
    sel = -1;
    foreach (q[i]) if (sel < 0 && q[i].ar && q[i].br) sel = i;
    iss = (sel >= 0) && in_fu_alu_ready && !in_flush;
    acc = in_dispatch_valid && (q.size() < RS) && !in_flush;
    if (in_flush) begin
      q.delete();
      e_start = 1'b0;
      return;
    end
    e_start = iss;
    if (iss) begin
      e_op  = q[sel].op;
      e_va  = q[sel].va;
      e_vb  = q[sel].vb;
      e_dst = q[sel].dst;
      e_sn  = q[sel].sn;
      e_nz  = q[sel].nz;
      e_cd  = q[sel].cd;
    end
    if (in_fu_done) begin
      foreach (q[i]) begin
        if (!q[i].ar && q[i].at == in_fu_dst_rob_index) begin
          q[i].ar = 1'b1;
          q[i].va = in_fu_value;
        end
        if (!q[i].br && q[i].bt == in_fu_dst_rob_index) begin
          q[i].br = 1'b1;
          q[i].vb = in_fu_value;
        end
      end
    end
    if (iss) q.delete(sel);
    if (acc) begin
      e.op  = in_dispatch_fu_op;
      e.va  = in_dispatch_val_a;
      e.vb  = in_dispatch_val_b;
      e.ar  = in_dispatch_a_ready;
      e.br  = in_dispatch_b_ready;
      e.at  = in_dispatch_a_tag;
      e.bt  = in_dispatch_b_tag;
      e.dst = in_dispatch_dst_rob_index;
      e.sn  = in_dispatch_set_nzcv;
      e.nz  = in_dispatch_nzcv;
      e.cd  = in_dispatch_cond;
      if (!e.ar && in_fu_done && e.at == in_fu_dst_rob_index) begin
        e.ar = 1'b1;
        e.va = in_fu_value;
      end
      if (!e.br && in_fu_done && e.bt == in_fu_dst_rob_index) begin
        e.br = 1'b1;
        e.vb = in_fu_value;
      end
      q.push_back(e);
    end
  endtask

  task automatic check_all();
    chk("start", out_fu_alu_start, e_start);
    chk("full", out_dispatch_full, (q.size() == RS));
    chk("fu_op", out_fu_alu_fu_op, e_op);
    chk("val_a", out_fu_alu_val_a, e_va);
    chk("val_b", out_fu_alu_val_b, e_vb);
    chk("dst", out_fu_alu_dst_rob_index, e_dst);
    chk("set_nzcv", out_fu_alu_set_nzcv, e_sn);
    chk("nzcv", out_fu_alu_nzcv, e_nz);
    chk("cond", out_fu_alu_cond, e_cd);
  endtask

  task automatic tick();
    model_edge();
    @(posedge in_clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    in_dispatch_valid = 1'b0;
    in_fu_done        = 1'b0;
    in_flush          = 1'b0;
  endtask

  task automatic disp(input fu_op_t op, input logic [63:0] va, input logic [63:0] vb,
                      input logic ar, input logic br, input logic [3:0] at,
                      input logic [3:0] bt, input logic [3:0] dst);
    in_dispatch_valid         = 1'b1;
    in_dispatch_fu_op         = op;
    in_dispatch_val_a         = va;
    in_dispatch_val_b         = vb;
    in_dispatch_a_ready       = ar;
    in_dispatch_b_ready       = br;
    in_dispatch_a_tag         = at;
    in_dispatch_b_tag         = bt;
    in_dispatch_dst_rob_index = dst;
    in_dispatch_set_nzcv      = dst[0];
    in_dispatch_nzcv          = ~dst;
    in_dispatch_cond          = dst ^ 4'h5;
  endtask

  task automatic bcast(input logic [3:0] tag, input logic [63:0] val);
    in_fu_done          = 1'b1;
    in_fu_dst_rob_index = tag;
    in_fu_value         = val;
  endtask

  initial begin
    in_clk = 1'b0;
    in_rst = 1'b1;
    in_fu_alu_ready = 1'b0;
    in_dispatch_fu_op = FU_PLUS;
    in_dispatch_val_a = '0;
    in_dispatch_val_b = '0;
    in_dispatch_a_ready = 1'b0;
    in_dispatch_b_ready = 1'b0;
    in_dispatch_a_tag = '0;
    in_dispatch_b_tag = '0;
    in_dispatch_dst_rob_index = '0;
    in_dispatch_set_nzcv = 1'b0;
    in_dispatch_nzcv = '0;
    in_dispatch_cond = '0;
    in_fu_dst_rob_index = '0;
    in_fu_value = '0;
    idle();
    model_reset();
    #1;
    check_all();
    #11;
    in_rst = 1'b0;

    // Basic issue: both operands ready, one-cycle minimum residency.
    in_fu_alu_ready = 1'b1;
    disp(FU_PLUS, 64'd5, 64'd7, 1, 1, 4'd0, 4'd0, 4'd3);
    tick();
    chk("t1_no_early_start", out_fu_alu_start, 1'b0);
    idle();
    tick();
    chk("t1_start", out_fu_alu_start, 1'b1);
    chk("t1_val_a", out_fu_alu_val_a, 64'd5);
    chk("t1_val_b", out_fu_alu_val_b, 64'd7);
    chk("t1_dst", out_fu_alu_dst_rob_index, 4'd3);
    tick();
    chk("t1_single_pulse", out_fu_alu_start, 1'b0);

    // Wakeup from a later broadcast, then dispatch bypass from a same-cycle broadcast.
    disp(FU_MINUS, 64'd0, 64'd1, 0, 1, 4'd2, 4'd0, 4'd4);
    tick();
    idle();
    tick();
    bcast(4'd2, 64'h10);
    tick();
    chk("t2_wake_edge", out_fu_alu_start, 1'b0);
    idle();
    tick();
    chk("t2_start", out_fu_alu_start, 1'b1);
    chk("t2_val_a", out_fu_alu_val_a, 64'h10);
    disp(FU_AND, 64'd0, 64'd2, 0, 1, 4'd2, 4'd0, 4'd5);
    bcast(4'd2, 64'h22);
    tick();
    chk("t2b_no_early", out_fu_alu_start, 1'b0);
    idle();
    tick();
    chk("t2b_start", out_fu_alu_start, 1'b1);
    chk("t2b_val_a", out_fu_alu_val_a, 64'h22);

    // Fill with only slots 1 and 3 ready; out-of-order issue and compaction.
    in_fu_alu_ready = 1'b0;
    disp(FU_ORR, 64'd0, 64'd8, 0, 1, 4'd5, 4'd0, 4'd8);  tick();
    disp(FU_EOR, 64'd9, 64'd9, 1, 1, 4'd0, 4'd0, 4'd9);  tick();
    disp(FU_LSL, 64'd0, 64'hA, 0, 1, 4'd6, 4'd0, 4'd10); tick();
    disp(FU_LSR, 64'hB, 64'hB, 1, 1, 4'd0, 4'd0, 4'd11); tick();
    chk("t3_full", out_dispatch_full, 1'b1);
    in_fu_alu_ready = 1'b1;
    disp(FU_MOV, 64'hC, 64'hC, 1, 1, 4'd0, 4'd0, 4'd12);
    tick();
    chk("t3_first_dst", out_fu_alu_dst_rob_index, 4'd9);
    chk("t4_full_drops", out_dispatch_full, 1'b0);
    in_fu_alu_ready = 1'b0;
    disp(FU_MOV, 64'h12, 64'h12, 1, 1, 4'd0, 4'd0, 4'd12);
    tick();
    chk("t4_refill_full", out_dispatch_full, 1'b1);
    idle();
    in_fu_alu_ready = 1'b1;
    tick();
    chk("t3_second_dst", out_fu_alu_dst_rob_index, 4'd11);
    tick();
    chk("t4_slot3_dst", out_fu_alu_dst_rob_index, 4'd12);
    chk("t4_slot3_val", out_fu_alu_val_a, 64'h12);
    bcast(4'd5, 64'h55);
    tick();
    chk("t3_none_ready", out_fu_alu_start, 1'b0);
    bcast(4'd6, 64'h66);
    tick();
    chk("t3_e0_dst", out_fu_alu_dst_rob_index, 4'd8);
    chk("t3_e0_val", out_fu_alu_val_a, 64'h55);
    idle();
    tick();
    chk("t3_e2_dst", out_fu_alu_dst_rob_index, 4'd10);
    chk("t3_e2_val", out_fu_alu_val_a, 64'h66);
    tick();

    // Stall with two ready entries, then back-to-back release.
    in_fu_alu_ready = 1'b0;
    disp(FU_PLUS, 64'd1, 64'd1, 1, 1, 4'd0, 4'd0, 4'd1); tick();
    disp(FU_PLUS, 64'd2, 64'd2, 1, 1, 4'd0, 4'd0, 4'd2); tick();
    idle();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t5_stalled", out_fu_alu_start, 1'b0);
    end
    in_fu_alu_ready = 1'b1;
    tick();
    chk("t5_first", out_fu_alu_dst_rob_index, 4'd1);
    tick();
    chk("t5_second_start", out_fu_alu_start, 1'b1);
    chk("t5_second", out_fu_alu_dst_rob_index, 4'd2);
    tick();
    chk("t5_done", out_fu_alu_start, 1'b0);

    // Flush with three valid entries and a concurrent dispatch.
    in_fu_alu_ready = 1'b0;
    disp(FU_PLUS, 64'd3, 64'd3, 1, 1, 4'd0, 4'd0, 4'd13); tick();
    disp(FU_PLUS, 64'd4, 64'd4, 1, 1, 4'd0, 4'd0, 4'd14); tick();
    disp(FU_PLUS, 64'd5, 64'd5, 1, 1, 4'd0, 4'd0, 4'd15); tick();
    in_flush = 1'b1;
    in_fu_alu_ready = 1'b1;
    tick();
    chk("t6_flush_start", out_fu_alu_start, 1'b0);
    chk("t6_flush_payload_kept", out_fu_alu_dst_rob_index, 4'd2);
    idle();
    tick();
    chk("t6_empty", out_fu_alu_start, 1'b0);

    // Asynchronous reset in the middle of a cycle.
    disp(FU_EOR, 64'h77, 64'h7, 1, 1, 4'd0, 4'd0, 4'd7); tick();
    disp(FU_EOR, 64'h88, 64'h8, 1, 1, 4'd0, 4'd0, 4'd8); tick();
    chk("t7_pre_reset_start", out_fu_alu_start, 1'b1);
    idle();
    #2;
    in_rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("t7_async_val_a", out_fu_alu_val_a, 64'd0);
    #2;
    in_rst = 1'b0;
    tick();
    tick();
    chk("t7_discarded", out_fu_alu_start, 1'b0);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      in_dispatch_valid = ($urandom_range(0, 9) < 6);
      in_dispatch_fu_op = fu_op_t'($urandom_range(0, 7));
      in_dispatch_val_a = {$urandom, $urandom};
      in_dispatch_val_b = {$urandom, $urandom};
      in_dispatch_a_ready = $urandom_range(0, 1) == 1;
      in_dispatch_b_ready = $urandom_range(0, 1) == 1;
      in_dispatch_a_tag = 4'($urandom_range(0, 3));
      in_dispatch_b_tag = 4'($urandom_range(0, 3));
      in_dispatch_dst_rob_index = 4'($urandom_range(0, 15));
      in_dispatch_set_nzcv = $urandom_range(0, 1) == 1;
      in_dispatch_nzcv = 4'($urandom_range(0, 15));
      in_dispatch_cond = 4'($urandom_range(0, 15));
      in_fu_done = $urandom_range(0, 1) == 1;
      in_fu_dst_rob_index = 4'($urandom_range(0, 3));
      in_fu_value = {$urandom, $urandom};
      in_fu_alu_ready = ($urandom_range(0, 9) < 7);
      in_flush = ($urandom_range(0, 39) == 0);
      tick();
    end
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
